// File: rtl/inv_modp.sv
// Modular inverse over p = 2^255 - 19 via Fermat: result = z^(p-2) mod p.
// Left-to-right square-and-multiply; every field multiply goes to an external
// mod-p multiplier through a mul_start / mul_done handshake.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start, z            inversion request and operand (z taken on accept in IDLE)
//   busy                high in every state except IDLE
//   done, result        one-cycle completion pulse; result held until next accept
//   mul_start           one-cycle request to the multiplier
//   mul_x, mul_y        multiplier operands, held until mul_done is seen
//   mul_prod, mul_done  multiplier product and its one-cycle valid pulse
module inv_modp #(
  parameter int unsigned N = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] z,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         mul_start,
  output logic [N-1:0] mul_x,
  output logic [N-1:0] mul_y,
  input  logic [N-1:0] mul_prod,
  input  logic         mul_done
);

  localparam int unsigned      CNT_W    = 8;
  // Exponent bit 254 is consumed by loading acc with z, so the walk starts at 253.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(253);
  localparam logic [CNT_W-1:0] CNT_TAIL = CNT_W'(5);
  // Low exponent bits 4..0 = 01011; every bit from 5 upward is 1.
  localparam logic [7:0]       E_LOW    = 8'b0000_1011;

  typedef enum logic [2:0] {
    IDLE,
    SQR_ISSUE,
    SQR_WAIT,
    MUL_ISSUE,
    MUL_WAIT,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       acc_q, acc_d;
  logic [N-1:0]       zreg_q, zreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       mul_x_d, mul_y_d, result_d;
  logic               mul_start_d, done_d, busy_d;
  logic               e_bit_c;

  // Current exponent bit selected by cnt.
  assign e_bit_c = (cnt_q >= CNT_TAIL) ? 1'b1 : E_LOW[cnt_q[2:0]];

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      zreg_q    <= '0;
      cnt_q     <= '0;
      mul_x     <= '0;
      mul_y     <= '0;
      mul_start <= 1'b0;
      result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      zreg_q    <= zreg_d;
      cnt_q     <= cnt_d;
      mul_x     <= mul_x_d;
      mul_y     <= mul_y_d;
      mul_start <= mul_start_d;
      result    <= result_d;
      done      <= done_d;
      busy      <= busy_d;
    end
  end

  // Next state and next register values. Operands for the next multiply are
  // loaded on the transition into an issue state, so the issue cycle already
  // presents them and they stay put until the matching mul_done.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    zreg_d      = zreg_q;
    cnt_d       = cnt_q;
    mul_x_d     = mul_x;
    mul_y_d     = mul_y;
    mul_start_d = 1'b0;
    result_d    = result;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d       = z;
          zreg_d      = z;
          cnt_d       = CNT_INIT;
          mul_x_d     = z;
          mul_y_d     = z;
          mul_start_d = 1'b1;
          state_d     = SQR_ISSUE;
        end
      end

      SQR_ISSUE: state_d = SQR_WAIT;

      SQR_WAIT: begin
        if (mul_done) begin
          acc_d = mul_prod;
          if (e_bit_c) begin
            mul_x_d     = mul_prod;
            mul_y_d     = zreg_q;
            mul_start_d = 1'b1;
            state_d     = MUL_ISSUE;
          end else if (cnt_q == '0) begin
            state_d = DONE;
          end else begin
            cnt_d       = cnt_q - CNT_W'(1);
            mul_x_d     = mul_prod;
            mul_y_d     = mul_prod;
            mul_start_d = 1'b1;
            state_d     = SQR_ISSUE;
          end
        end
      end

      MUL_ISSUE: state_d = MUL_WAIT;

      MUL_WAIT: begin
        if (mul_done) begin
          acc_d = mul_prod;
          if (cnt_q == '0) begin
            state_d = DONE;
          end else begin
            cnt_d       = cnt_q - CNT_W'(1);
            mul_x_d     = mul_prod;
            mul_y_d     = mul_prod;
            mul_start_d = 1'b1;
            state_d     = SQR_ISSUE;
          end
        end
      end

      DONE: begin
        result_d = acc_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_inv_modp.sv
// Bench for inv_modp: behavioural mod-p multiplier with programmable latency,
// results compared against a Fermat exponentiation reference.
module tb_inv_modp;

  localparam int unsigned N = 255;
  localparam logic [255:0] P = (256'd1 << 255) - 256'd19;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] z;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         mul_start;
  logic [N-1:0] mul_x;
  logic [N-1:0] mul_y;
  logic [N-1:0] mul_prod;
  logic         mul_done;

  int          total   = 0;
  int          bad     = 0;
  int unsigned mul_d   = 1;
  int          mul_ops = 0;

  inv_modp #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .z         (z),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .mul_start (mul_start),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_prod  (mul_prod),
    .mul_done  (mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [N-1:0] mulmod(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [511:0] t;
    t = 512'(a) * 512'(b);
    t = t % 512'(P);
    return N'(t);
  endfunction

  // Right-to-left binary exponentiation, independent of the DUT's bit walk.
  function automatic logic [N-1:0] powmod(input logic [N-1:0] base, input logic [255:0] e);
    logic [N-1:0] r, b;
    r = N'(1);
    b = mulmod(base, N'(1));
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = mulmod(r, b);
      b = mulmod(b, b);
    end
    return r;
  endfunction

  function automatic logic [N-1:0] inv_ref(input logic [N-1:0] v);
    return powmod(v, P - 256'd2);
  endfunction

  function automatic logic [N-1:0] rand_z();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[N-1:0];
  endfunction

  // Behavioural multiplier: answers exactly mul_d cycles after mul_start and
  // checks that operands stay stable while it works.
  initial begin : mul_model
    logic [N-1:0] cx, cy;
    bit           aborted;
    int unsigned  d;
    mul_done = 1'b0;
    mul_prod = '0;
    forever begin
      @(negedge clk);
      if (rst && mul_start) begin
        cx      = mul_x;
        cy      = mul_y;
        d       = mul_d;
        aborted = 1'b0;
        mul_ops++;
        for (int k = 0; k < int'(d); k++) begin
          @(posedge clk);
          if (k == int'(d) - 1) begin
            #1;
            mul_done = 1'b1;
            mul_prod = mulmod(cx, cy);
          end
          @(negedge clk);
          if (!rst) aborted = 1'b1;
          if (!aborted) begin
            check("mul_x_hold", 256'(mul_x), 256'(cx));
            check("mul_y_hold", 256'(mul_y), 256'(cy));
            check("mul_start_low", 256'(mul_start), 256'(0));
          end
        end
        @(posedge clk);
        #1 mul_done = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      256'(busy),      256'(0));
    check({tag, "_done"},      256'(done),      256'(0));
    check({tag, "_mul_start"}, 256'(mul_start), 256'(0));
    check({tag, "_result"},    256'(result),    256'(0));
    check({tag, "_mul_x"},     256'(mul_x),     256'(0));
    check({tag, "_mul_y"},     256'(mul_y),     256'(0));
  endtask

  // One inversion; cyc counts edges from the accept edge to the done cycle.
  task automatic run_inv(input logic [N-1:0] zin, input int unsigned d, input bit poke,
                         output logic [N-1:0] res, output int cyc);
    mul_d   = d;
    mul_ops = 0;
    @(posedge clk);
    #1;
    z     = zin;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    z     = rand_z();
    cyc   = 0;
    while (cyc < 10000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done) break;
      if (poke && cyc == 40) begin
        start = 1'b1;
        z     = rand_z();
      end
      if (poke && cyc == 41) start = 1'b0;
      if (poke && cyc == 60) check("busy_mid", 256'(busy), 256'(1));
    end
    check("done_seen", 256'(done), 256'(1));
    res = result;
    @(negedge clk);
    check("done_pulse", 256'(done), 256'(0));
    check("result_hold", 256'(result), 256'(res));
    check("busy_after", 256'(busy), 256'(0));
  endtask

  initial begin : main
    logic [N-1:0] res, zr;
    int           cyc;
    int unsigned  d;

    rst   = 1'b0;
    start = 1'b0;
    z     = '0;
    #3;
    check_idle_outputs("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    run_inv(N'(1), 1, 1'b0, res, cyc);
    check("z1_res", 256'(res), 256'(1));
    check("z1_lat", 256'(cyc), 256'(1013));
    check("z1_ops", 256'(mul_ops), 256'(506));

    run_inv(N'(2), 1, 1'b0, res, cyc);
    check("z2_res", 256'(res), (256'd1 << 254) - 256'd9);

    run_inv(N'(P - 256'd1), 1, 1'b0, res, cyc);
    check("zpm1_res", 256'(res), P - 256'd1);

    run_inv(N'(0), 1, 1'b0, res, cyc);
    check("z0_res", 256'(res), 256'(0));
    check("z0_ops", 256'(mul_ops), 256'(506));

    run_inv(N'(P + 256'd5), 2, 1'b0, res, cyc);
    check("zbig_res", 256'(res), 256'(inv_ref(N'(5))));
    check("zbig_lat", 256'(cyc), 256'(506 * 3 + 1));

    for (int i = 0; i < 5; i++) begin
      d  = $urandom_range(8, 1);
      zr = rand_z();
      run_inv(zr, d, 1'b1, res, cyc);
      check("rnd_res", 256'(res), 256'(inv_ref(zr)));
      if (mulmod(zr, N'(1)) != '0) check("rnd_prod", 256'(mulmod(zr, res)), 256'(1));
      check("rnd_lat", 256'(cyc), 256'(506 * (d + 1) + 1));
      check("rnd_ops", 256'(mul_ops), 256'(506));
    end

    // Reset in the middle of an inversion, just after a multiply is issued.
    mul_d = 8;
    @(posedge clk);
    #1;
    z     = rand_z();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (100) @(negedge clk);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mul_start) break;
    end
    check("rst_found", 256'(mul_start), 256'(1));
    #2 rst = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    @(negedge clk);
    #2 rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("stale_busy", 256'(busy), 256'(0));
      check("stale_mul_start", 256'(mul_start), 256'(0));
    end
    check("stale_done", 256'(done), 256'(0));

    run_inv(N'(3), 1, 1'b0, res, cyc);
    check("z3_res", 256'(res), (256'd2 * P + 256'd1) / 256'd3);
    check("z3_lat", 256'(cyc), 256'(1013));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
